rob_wb_arbiter: RTL and testbench
=================================

Name: rob_wb_arbiter

Overview:
Shares the N_WRITE_PORTS random-access write ports of the FIFO RAM (ROB/issue buffer) among N_REQ writeback requesters (functional units, LSU).
- Each cycle, grants up to N_WRITE_PORTS requests in rotating round-robin order; requesters that target the same entry are resolved so only one write per address issues.
- Granted writes are registered and driven onto the RAM wr_en/wr_addr/wr_data ports one cycle later.
- Sits between the execution-unit writeback buses and the FIFO RAM write-port inputs.

Parameters:
DATA_WIDTH, 32, width of each write payload (matches RAM entry width)
FIFO_DEPTH, 8, number of RAM entries; PTR_WIDTH = $clog2(FIFO_DEPTH) (localparam)
N_REQ, 4, number of writeback requesters
N_WRITE_PORTS, 2, number of RAM write ports arbitrated; must be <= N_REQ
REQ_IDX_WIDTH, $clog2(N_REQ) (localparam), width of the round-robin pointer

Ports:
clk  in  1  clock
rst_aL  in  1  asynchronous active-low reset
flush  in  1  pipeline flush: kill all grants this cycle
req_valid  in  N_REQ  requester i has a write pending
req_addr  in  N_REQ x PTR_WIDTH  target entry per requester
req_data  in  N_REQ x DATA_WIDTH  write data per requester
req_ready  out  N_REQ  combinational grant; handshake = req_valid[i] & req_ready[i]
wr_en  out  N_WRITE_PORTS  registered write enable to RAM
wr_addr  out  N_WRITE_PORTS x PTR_WIDTH  registered write address
wr_data  out  N_WRITE_PORTS x DATA_WIDTH  registered write data
rr_ptr  out  REQ_IDX_WIDTH  current highest-priority requester (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_aL. While rst_aL is low: wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0.
- Outputs during reset: req_ready is combinational and is forced to 0 while rst_aL is low.
- Reset mid-operation: asserting rst_aL clears wr_en immediately without waiting for a clock edge. Any in-flight write is dropped, and requesters re-present it after reset.
- Scan order: requesters are examined in order rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
- Port assignment: each valid requester whose req_addr differs from every address already granted this cycle takes the next free port, starting from port 0. The scan stops when all N_WRITE_PORTS ports are filled.
- Address conflict: a valid requester whose address matches an already-granted address gets no grant. It waits with req_ready=0 and must hold its valid/addr/data stable.
- Grant type: req_ready[i] is a pure function of req_valid, req_addr, rr_ptr, flush and rst_aL. There is no back-pressure from the RAM; the RAM always accepts a write.
- Latency: a handshake in cycle T drives wr_en/wr_addr/wr_data for port k during cycle T+1, and the RAM entry updates at the end of T+1. Unused ports have wr_en=0; their wr_addr/wr_data hold their previous values.
- Pointer update: if at least one grant occurs, rr_ptr_next = (index of the last granted requester + 1) mod N_REQ. With no grants, rr_ptr holds.
- Fairness: a requester that stays valid is granted within ceil(N_REQ / N_WRITE_PORTS) + 1 cycles, absent flush and conflicts.
- Flush: req_ready = 0 in that cycle, wr_en = 0 in the next cycle, and rr_ptr resets to 0. Writes already registered (wr_en high during the flush cycle) still complete.
- Flush + valid requests: flush overrides them; no handshake occurs.
- Address compare width: PTR_WIDTH bits; there is no wrap or overflow arithmetic beyond the mod-N_REQ pointer increment.

Decomposition:
- Shared package (rob_pkg) holds:
  - PTR_WIDTH, derived from FIFO_DEPTH;
  - the wb_req_t struct {addr, data};
  - the wb_port_t struct {en, addr, data}.
- One sub-module, rr_multi_grant: combinational rotated priority scan with address-conflict masking. Inputs: valid vector, addresses, rr_ptr. Outputs: grant vector, per-port requester index, per-port valid, last-granted index.
- rob_wb_arbiter wraps rr_multi_grant with the output registers, pointer register and flush/reset logic.

Test Plan:
1. Reset: hold rst_aL=0 with all req_valid=1 -> req_ready=0000, wr_en=00, rr_ptr=0. Release -> normal grants start the next cycle.
2. Round-robin, 4 valid, addrs 0/1/2/3, rr_ptr=0:
   - cycle 0: req_ready=0011; next cycle wr_en=11, wr_addr={1,0}, rr_ptr=2.
   - cycle 1: req_ready=1100; next cycle wr_addr={3,2}, rr_ptr=0.
3. Conflict: req0 and req1 both addr 5, req2 addr 6, rr_ptr=0 -> req_ready=0101, port0=(5,data0), port1=(6,data2), rr_ptr=3. Next cycle req1 is granted.
4. Wrap, single requester: only req3 valid, rr_ptr=1 -> req_ready=1000, next wr_en=01 with wr_addr[0]=req3 addr, rr_ptr=0.
5. Flush: all valid, flush=1, rr_ptr=2 -> req_ready=0000, next cycle wr_en=00, rr_ptr=0. Grants resume the following cycle with req_ready=0011.
6. Async reset mid-operation: wr_en=11, drop rst_aL between edges -> wr_en=00 immediately, rr_ptr=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and default widths for the ROB writeback path.
package rob_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PTR_WIDTH      = $clog2(FIFO_DEPTH_DEF);

  typedef struct packed {
    logic [PTR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                      en;
    logic [PTR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Rotated priority scan that hands out up to N_WRITE_PORTS grants per cycle,
// letting at most one requester claim any given entry address.
module rr_multi_grant #(
  parameter  int N_REQ         = 4,
  parameter  int N_WRITE_PORTS = 2,
  parameter  int PTR_WIDTH     = 3,
  localparam int IDX_W         = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]                        valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]         addr,
  input  logic [IDX_W-1:0]                        rr_ptr,
  output logic [N_REQ-1:0]                        grant,
  output logic [N_WRITE_PORTS-1:0][IDX_W-1:0]     port_idx,
  output logic [N_WRITE_PORTS-1:0]                port_vld,
  output logic [IDX_W-1:0]                        last_idx
);

  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] port_addr_s;
  logic [IDX_W-1:0]                        cand_s;
  logic                                    hit_s;
  logic                                    placed_s;

  // base and off are both below N_REQ, so a single subtract wraps the sum
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= N_REQ) ? IDX_W'(sum - N_REQ) : IDX_W'(sum);
  endfunction

  // Scan requesters from rr_ptr; ports fill in order so the first free port is the next one
  always_comb begin
    grant       = '0;
    port_idx    = '0;
    port_vld    = '0;
    port_addr_s = '0;
    last_idx    = rr_ptr;
    cand_s      = '0;
    hit_s       = 1'b0;
    placed_s    = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      cand_s   = rot_idx(rr_ptr, j);
      hit_s    = 1'b0;
      placed_s = 1'b0;
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        if (port_vld[k] && (port_addr_s[k] == addr[cand_s])) begin
          hit_s = 1'b1;
        end else begin
          hit_s = hit_s;
        end
      end
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        if (valid[cand_s] && !hit_s && !placed_s && !port_vld[k]) begin
          port_vld[k]    = 1'b1;
          port_idx[k]    = cand_s;
          port_addr_s[k] = addr[cand_s];
          grant[cand_s]  = 1'b1;
          last_idx       = cand_s;
          placed_s       = 1'b1;
        end else begin
          placed_s = placed_s;
        end
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the ROB RAM write ports among writeback units;
// grants are combinational, the RAM write ports are registered.
module rob_wb_arbiter #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int FIFO_DEPTH    = 8,
  parameter  int N_REQ         = 4,
  parameter  int N_WRITE_PORTS = 2,
  localparam int PTR_WIDTH     = $clog2(FIFO_DEPTH),
  localparam int REQ_IDX_WIDTH = $clog2(N_REQ)
) (
  input  logic                                     clk,
  input  logic                                     rst_aL,
  input  logic                                     flush,
  input  logic [N_REQ-1:0]                         req_valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]          req_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]         req_data,
  output logic [N_REQ-1:0]                         req_ready,
  output logic [N_WRITE_PORTS-1:0]                 wr_en,
  output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  wr_addr,
  output logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
  output logic [REQ_IDX_WIDTH-1:0]                 rr_ptr
);

  import rob_pkg::*;

  logic [N_REQ-1:0]                            grant_s;
  logic [N_WRITE_PORTS-1:0][REQ_IDX_WIDTH-1:0] port_idx_s;
  logic [N_WRITE_PORTS-1:0]                    port_vld_s;
  logic [REQ_IDX_WIDTH-1:0]                    last_idx_s;
  logic [REQ_IDX_WIDTH-1:0]                    ptr_next_s;
  logic [REQ_IDX_WIDTH-1:0]                    rr_ptr_r;
  wb_port_t                                    port_r [N_WRITE_PORTS];

  rr_multi_grant #(
    .N_REQ         (N_REQ),
    .N_WRITE_PORTS (N_WRITE_PORTS),
    .PTR_WIDTH     (PTR_WIDTH)
  ) u_grant (
    .valid    (req_valid),
    .addr     (req_addr),
    .rr_ptr   (rr_ptr_r),
    .grant    (grant_s),
    .port_idx (port_idx_s),
    .port_vld (port_vld_s),
    .last_idx (last_idx_s)
  );

  assign ptr_next_s = (last_idx_s == REQ_IDX_WIDTH'(N_REQ - 1)) ? '0
                                                                : last_idx_s + REQ_IDX_WIDTH'(1);

  // Handshake gating: reset and flush both kill every grant
  always_comb begin
    req_ready = '0;
    if (!rst_aL || flush) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
  end

  // Write-port and pointer registers; flush drops new grants but leaves held addr/data alone
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        port_r[k] <= '0;
      end
      rr_ptr_r <= '0;
    end else if (flush) begin
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        port_r[k].en <= 1'b0;
      end
      rr_ptr_r <= '0;
    end else begin
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        port_r[k].en <= port_vld_s[k];
        if (port_vld_s[k]) begin
          port_r[k].addr <= req_addr[port_idx_s[k]];
          port_r[k].data <= req_data[port_idx_s[k]];
        end
      end
      if (|port_vld_s) begin
        rr_ptr_r <= ptr_next_s;
      end
    end
  end

  // Unpack the port registers onto the RAM-facing buses
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      wr_en[k]   = port_r[k].en;
      wr_addr[k] = port_r[k].addr;
      wr_data[k] = port_r[k].data;
    end
  end

  assign rr_ptr = rr_ptr_r;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed plus randomized bench for rob_wb_arbiter against a queue-based reference model.
module tb_rob_wb_arbiter;

  logic             clk;
  logic             rst_aL;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][2:0]  req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [1:0]       wr_en;
  logic [1:0][2:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       rr_ptr;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          ptr_m;
  logic [1:0]  en_m;
  logic [2:0]  addr_m [2];
  logic [31:0] data_m [2];
  logic [3:0]  g_m;
  logic [3:0]  hs_m;
  int          pi_m [2];
  int          np_m;
  int          last_m;

  rob_wb_arbiter dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk requesters from the pointer, keeping a list of addresses already claimed
  task automatic compute_model();
    logic [2:0] used [$];
    int idx;
    bit hit;
    used.delete();
    g_m = 4'b0000;
    np_m = 0;
    last_m = ptr_m;
    for (int j = 0; j < 4; j++) begin
      idx = (ptr_m + j) % 4;
      hit = 1'b0;
      foreach (used[u]) if (used[u] == req_addr[idx]) hit = 1'b1;
      if (np_m < 2 && req_valid[idx] && !hit) begin
        g_m[idx] = 1'b1;
        pi_m[np_m] = idx;
        used.push_back(req_addr[idx]);
        np_m++;
        last_m = idx;
      end
    end
  endtask

  task automatic reset_model();
    ptr_m = 0;
    en_m = 2'b00;
    hs_m = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      addr_m[k] = 3'd0;
      data_m[k] = 32'd0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(en_m));
    chk({tag, "_rr_ptr"}, 64'(rr_ptr), 64'(ptr_m));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_wr_addr%0d", tag, k), 64'(wr_addr[k]), 64'(addr_m[k]));
      chk($sformatf("%s_wr_data%0d", tag, k), 64'(wr_data[k]), 64'(data_m[k]));
    end
  endtask

  // Called just after a rising edge with inputs applied; checks ready, clocks, checks ports
  task automatic cycle(input string tag);
    #1;
    compute_model();
    chk({tag, "_ready"}, 64'(req_ready), flush ? 64'd0 : 64'(g_m));
    @(posedge clk);
    #1;
    if (flush) begin
      en_m = 2'b00;
      ptr_m = 0;
      hs_m = 4'b0000;
    end else begin
      hs_m = g_m;
      for (int k = 0; k < 2; k++) begin
        en_m[k] = (k < np_m);
        if (k < np_m) begin
          addr_m[k] = req_addr[pi_m[k]];
          data_m[k] = req_data[pi_m[k]];
        end
      end
      if (np_m > 0) ptr_m = (last_m + 1) % 4;
    end
    check_outputs(tag);
  endtask

  task automatic set_req(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
    req_valid = v;
    req_addr[0] = 3'(a0);
    req_addr[1] = 3'(a1);
    req_addr[2] = 3'(a2);
    req_addr[3] = 3'(a3);
  endtask

  initial begin
    rst_aL = 1'b0;
    flush = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 3'(i);
      req_data[i] = 32'hA000_0000 + 32'(i);
    end
    reset_model();

    // reset holds everything quiet even with requests pending
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready", 64'(req_ready), 64'd0);
    check_outputs("rst_hold");
    @(negedge clk);
    rst_aL = 1'b1;

    // round robin over four distinct addresses
    set_req(4'b1111, 0, 1, 2, 3);
    cycle("rr0");
    chk("rr0_ptr_lit", 64'(rr_ptr), 64'd2);
    cycle("rr1");
    chk("rr1_addr_lit", 64'({wr_addr[1], wr_addr[0]}), 64'({3'd3, 3'd2}));

    // address conflict: req1 loses to req0, retries next cycle
    set_req(4'b0111, 5, 5, 6, 0);
    for (int i = 0; i < 4; i++) req_data[i] = $urandom;
    cycle("cf0");
    chk("cf0_ptr_lit", 64'(rr_ptr), 64'd3);
    set_req(4'b0010, 0, 5, 0, 0);
    cycle("cf1");

    // bring pointer to 1, then a lone req3 wraps back to 0
    set_req(4'b0001, 7, 0, 0, 0);
    cycle("wp0");
    set_req(4'b1000, 0, 0, 0, 4);
    req_data[3] = $urandom;
    cycle("wp1");
    chk("wp1_ptr_lit", 64'(rr_ptr), 64'd0);

    // flush with all valid at rr_ptr=2
    set_req(4'b1111, 0, 1, 2, 3);
    cycle("fl0");
    flush = 1'b1;
    cycle("fl1");
    flush = 1'b0;
    cycle("fl2");

    // async reset between edges while both ports are writing
    cycle("ar0");
    chk("ar0_en_lit", 64'(wr_en), 64'd3);
    #3;
    rst_aL = 1'b0;
    reset_model();
    #1;
    chk("ar_ready", 64'(req_ready), 64'd0);
    check_outputs("ar");
    @(negedge clk);
    rst_aL = 1'b1;
    cycle("ar1");

    // randomized traffic; ungranted requests stay stable until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(req_valid[i] && !hs_m[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_addr[i] = 3'($urandom_range(0, 4));
          req_data[i] = $urandom;
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
